// File: rtl/dmem_sensor_bridge.sv
// ============================================================================
// dmem_sensor_bridge: DMEM-port word RAM plus memory-mapped sensor sample FIFO.
// Optional sample-vs-threshold interrupt enabled by macro SENSOR_THRESH_CMP_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_sensor_bridge #(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 16,
  parameter int SAMPLE_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dmem_en,
  input  logic                dmem_we,
  input  logic [31:0]         dmem_addr,
  input  logic [31:0]         dmem_wdata,
  output logic [31:0]         dmem_rdata,
  input  logic                smp_valid,
  input  logic [SAMPLE_W-1:0] smp_data,
  output logic                alert_o,
  output logic                irq_o
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]         ram_mem  [RAM_WORDS];
  logic [SAMPLE_W-1:0] fifo_mem [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          alert_q, alert_d;
  logic          irq_q, irq_d;
  logic [31:0]   thresh_q, thresh_d;

  logic rd_req, wr_req;
  logic is_ram, is_status, is_sample, is_thresh, is_ctrl;
  logic empty, full, push, pop, drop, ctrl_wr;
  logic [31:0] head_ext, status_word;
  logic unused_addr_bits;

  assign rd_req    = dmem_en & ~dmem_we;
  assign wr_req    = dmem_en & dmem_we;
  assign is_ram    = ~dmem_addr[31];
  assign is_status = (dmem_addr[31:2] == 30'h2000_0000);
  assign is_sample = (dmem_addr[31:2] == 30'h2000_0001);
  assign is_thresh = (dmem_addr[31:2] == 30'h2000_0002);
  assign is_ctrl   = (dmem_addr[31:2] == 30'h2000_0003);
  assign unused_addr_bits = ^dmem_addr[1:0];

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  // full is judged on the pre-edge count, so a same-edge pop never makes room
  assign push    = smp_valid & ~full;
  assign drop    = smp_valid & full;
  assign pop     = rd_req & is_sample & ~empty;
  assign ctrl_wr = wr_req & is_ctrl;

  always_comb begin
    head_ext = {32{fifo_mem[rd_ptr_q][SAMPLE_W-1]}};
    head_ext[SAMPLE_W-1:0] = fifo_mem[rd_ptr_q];
  end

  always_comb begin
    status_word = '0;
    status_word[0] = empty;
    status_word[1] = full;
    status_word[2] = overflow_q;
    status_word[8 +: CW] = count_q;
  end

  always_comb begin
    dmem_rdata = '0;
    if (rd_req) begin
      if (is_ram)         dmem_rdata = ram_mem[dmem_addr[AW+1:2]];
      else if (is_status) dmem_rdata = status_word;
      else if (is_sample) dmem_rdata = empty ? 32'h0 : head_ext;
      else if (is_thresh) dmem_rdata = thresh_q;
      else if (is_ctrl)   dmem_rdata = {29'b0, irq_q, overflow_q, alert_q};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_req & is_ram) ram_mem[dmem_addr[AW+1:2]] <= dmem_wdata;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= smp_data;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    overflow_d = overflow_q;
    if (ctrl_wr & dmem_wdata[1]) overflow_d = 1'b0;
    if (drop)                    overflow_d = 1'b1;

    alert_d  = ctrl_wr ? dmem_wdata[0] : alert_q;
    thresh_d = (wr_req & is_thresh) ? dmem_wdata : thresh_q;
  end

`ifdef SENSOR_THRESH_CMP_EN
  logic [31:0] smp_ext;

  always_comb begin
    smp_ext = {32{smp_data[SAMPLE_W-1]}};
    smp_ext[SAMPLE_W-1:0] = smp_data;
  end

  // Event set is applied last so it wins over a same-edge firmware clear
  always_comb begin
    irq_d = irq_q;
    if (ctrl_wr & dmem_wdata[2]) irq_d = 1'b0;
    if (push && ($signed(smp_ext) > $signed(thresh_q))) irq_d = 1'b1;
  end
`else
  always_comb begin
    irq_d = 1'b0;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      alert_q    <= 1'b0;
      irq_q      <= 1'b0;
      thresh_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      alert_q    <= alert_d;
      irq_q      <= irq_d;
      thresh_q   <= thresh_d;
    end
  end

  assign alert_o = alert_q;
  assign irq_o   = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_sensor_bridge.sv
// ============================================================================
// tb_dmem_sensor_bridge: directed self-checking bench for dmem_sensor_bridge.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dmem_sensor_bridge;

  localparam logic [31:0] A_STATUS = 32'h8000_0000;
  localparam logic [31:0] A_SAMPLE = 32'h8000_0004;
  localparam logic [31:0] A_THRESH = 32'h8000_0008;
  localparam logic [31:0] A_CTRL   = 32'h8000_000C;

  logic        clk;
  logic        reset;
  logic        dmem_en;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        smp_valid;
  logic [15:0] smp_data;
  logic        alert_o;
  logic        irq_o;

  int checks   = 0;
  int failures = 0;

  dmem_sensor_bridge #(
    .RAM_WORDS (1024),
    .FIFO_DEPTH(16),
    .SAMPLE_W  (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .dmem_en   (dmem_en),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata),
    .smp_valid (smp_valid),
    .smp_data  (smp_data),
    .alert_o   (alert_o),
    .irq_o     (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    dmem_en = 1'b1; dmem_we = 1'b1; dmem_addr = a; dmem_wdata = d;
    @(posedge clk); #1;
    dmem_en = 1'b0; dmem_we = 1'b0;
  endtask

  task automatic lw(input logic [31:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    dmem_en = 1'b1; dmem_we = 1'b0; dmem_addr = a;
    #1 check(tag, dmem_rdata, exp);
    @(posedge clk); #1;
    dmem_en = 1'b0;
  endtask

  task automatic push(input logic [15:0] v);
    @(negedge clk);
    smp_valid = 1'b1; smp_data = v;
    @(posedge clk); #1;
    smp_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; dmem_en = 1'b0; dmem_we = 1'b0; dmem_addr = '0;
    dmem_wdata = '0; smp_valid = 1'b0; smp_data = '0;
    #12;
    check("reset_alert", {31'b0, alert_o}, 32'h0);
    check("reset_irq", {31'b0, irq_o}, 32'h0);
    dmem_addr = A_STATUS;
    #1 check("rdata_en0", dmem_rdata, 32'h0);
    @(negedge clk) reset = 1'b0;
    lw(A_STATUS, 32'h0000_0001, "reset_status");
    lw(A_THRESH, 32'h0, "reset_thresh");

    // RAM path and aliasing
    sw(32'h0000_0010, 32'hDEAD_BEEF);
    lw(32'h0000_0010, 32'hDEAD_BEEF, "ram_rd");
    lw(32'h0000_1010, 32'hDEAD_BEEF, "ram_alias");
    @(negedge clk);
    dmem_en = 1'b1; dmem_we = 1'b1; dmem_addr = 32'h0000_0010; dmem_wdata = 32'h1;
    #1 check("rdata_we1", dmem_rdata, 32'h0);
    @(posedge clk); #1 dmem_en = 1'b0; dmem_we = 1'b0;
    lw(32'h0000_0010, 32'h0000_0001, "ram_rewrite");
    lw(32'h8000_0100, 32'h0, "unmapped_rd");

    // FIFO order and sign extension
    push(16'h0005); push(16'hFFFE); push(16'h7FFF);
    lw(A_STATUS, 32'h0000_0300, "fifo_cnt3");
    lw(A_SAMPLE, 32'h0000_0005, "pop_pos");
    lw(A_SAMPLE, 32'hFFFF_FFFE, "pop_neg");
    lw(A_SAMPLE, 32'h0000_7FFF, "pop_max");
    lw(A_STATUS, 32'h0000_0001, "fifo_empty");
    lw(A_SAMPLE, 32'h0, "pop_empty");
    lw(A_STATUS, 32'h0000_0001, "empty_noerr");

    // Full and overflow
    for (int i = 1; i <= 17; i++) push(16'(i));
    lw(A_STATUS, 32'h0000_1006, "full_ovf");
    for (int i = 1; i <= 16; i++) lw(A_SAMPLE, 32'(i), "pop_full_seq");
    lw(A_STATUS, 32'h0000_0005, "drained_ovf");
    lw(A_CTRL, 32'h0000_0002, "ctrl_rd_ovf");
    sw(A_CTRL, 32'h2);
    lw(A_STATUS, 32'h0000_0001, "ovf_clear");

    // Simultaneous push and pop with two entries
    push(16'h000A); push(16'h000B);
    @(negedge clk);
    dmem_en = 1'b1; dmem_we = 1'b0; dmem_addr = A_SAMPLE; smp_valid = 1'b1; smp_data = 16'h000C;
    #1 check("simul_head", dmem_rdata, 32'h0000_000A);
    @(posedge clk); #1 dmem_en = 1'b0; smp_valid = 1'b0;
    lw(A_STATUS, 32'h0000_0200, "simul_cnt2");
    lw(A_SAMPLE, 32'h0000_000B, "simul_pop_b");
    lw(A_SAMPLE, 32'h0000_000C, "simul_pop_c");

    // Empty FIFO with same-edge push and read
    @(negedge clk);
    dmem_en = 1'b1; dmem_we = 1'b0; dmem_addr = A_SAMPLE; smp_valid = 1'b1; smp_data = 16'h0033;
    #1 check("empty_simul_rd", dmem_rdata, 32'h0);
    @(posedge clk); #1 dmem_en = 1'b0; smp_valid = 1'b0;
    lw(A_STATUS, 32'h0000_0100, "empty_simul_cnt");
    lw(A_SAMPLE, 32'h0000_0033, "empty_simul_pop");

    // Push while full with a same-edge pop still drops
    for (int i = 0; i < 16; i++) push(16'(100 + i));
    @(negedge clk);
    dmem_en = 1'b1; dmem_we = 1'b0; dmem_addr = A_SAMPLE; smp_valid = 1'b1; smp_data = 16'h0999;
    #1 check("full_simul_head", dmem_rdata, 32'd100);
    @(posedge clk); #1 dmem_en = 1'b0; smp_valid = 1'b0;
    lw(A_STATUS, 32'h0000_0F04, "full_simul_drop");
    push(16'd200);
    // Drop and overflow clear on the same edge: set wins
    @(negedge clk);
    dmem_en = 1'b1; dmem_we = 1'b1; dmem_addr = A_CTRL; dmem_wdata = 32'h2;
    smp_valid = 1'b1; smp_data = 16'h0777;
    @(posedge clk); #1 dmem_en = 1'b0; dmem_we = 1'b0; smp_valid = 1'b0;
    lw(A_STATUS, 32'h0000_1006, "ovf_set_wins");
    for (int i = 1; i < 16; i++) lw(A_SAMPLE, 32'(100 + i), "drain_seq");
    lw(A_SAMPLE, 32'd200, "drain_last");
    lw(A_STATUS, 32'h0000_0005, "drain_empty");

    // Alert, THRESH register, then async reset mid-stream
    sw(A_CTRL, 32'h3);
    check("alert_set", {31'b0, alert_o}, 32'h1);
    lw(A_CTRL, 32'h0000_0001, "ctrl_rd_alert");
    sw(A_THRESH, 32'h0000_1234);
    lw(A_THRESH, 32'h0000_1234, "thresh_rw");
    for (int i = 0; i < 5; i++) push(16'(i + 1));
    lw(A_STATUS, 32'h0000_0500, "pre_reset_cnt");
    @(negedge clk);
    dmem_en = 1'b1; dmem_we = 1'b0; dmem_addr = A_STATUS;
    #1 reset = 1'b1;
    #1 check("async_alert", {31'b0, alert_o}, 32'h0);
    check("async_status", dmem_rdata, 32'h0000_0001);
    dmem_addr = A_THRESH;
    #1 check("async_thresh", dmem_rdata, 32'h0);
    dmem_en = 1'b0;
    @(negedge clk) reset = 1'b0;
    lw(A_STATUS, 32'h0000_0001, "post_reset");

`ifdef SENSOR_THRESH_CMP_EN
    sw(A_THRESH, 32'd100);
    push(16'd100);
    check("irq_eq", {31'b0, irq_o}, 32'h0);
    push(16'd101);
    check("irq_gt", {31'b0, irq_o}, 32'h1);
    lw(A_CTRL, 32'h0000_0004, "ctrl_rd_irq");
    sw(A_CTRL, 32'h4);
    check("irq_clr", {31'b0, irq_o}, 32'h0);
    sw(A_THRESH, 32'hFFFF_FFF6);
    push(16'hFFFB);
    check("irq_neg", {31'b0, irq_o}, 32'h1);
    @(negedge clk);
    dmem_en = 1'b1; dmem_we = 1'b1; dmem_addr = A_CTRL; dmem_wdata = 32'h4;
    smp_valid = 1'b1; smp_data = 16'd200;
    @(posedge clk); #1 dmem_en = 1'b0; dmem_we = 1'b0; smp_valid = 1'b0;
    check("irq_set_wins", {31'b0, irq_o}, 32'h1);
    sw(A_CTRL, 32'h4);
    push(16'hFFF0);
    check("irq_below", {31'b0, irq_o}, 32'h0);
`else
    push(16'h7FFF);
    check("irq_off", {31'b0, irq_o}, 32'h0);
    sw(A_CTRL, 32'h4);
    lw(A_CTRL, 32'h0, "ctrl_rd_noirq");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
